stream_mux_rr: RTL
==================

STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 8, which sets the data word width in bits (legal range 1..64).
REQ-002 The block SHALL provide parameter NCH, default 4, which sets the number of input channels (legal range 2..16).
REQ-003 The block SHALL provide parameter RR_MODE, default 1, which selects round-robin arbitration when 1 and fixed priority (lowest index wins) when 0.
REQ-004 The block SHALL derive SW = max(1, clog2(NCH)) as the width of all channel-index signals.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-006 The ports SHALL be, clock and reset first:
- clk: input, 1 bit, the single clock; all state updates on the rising edge.
- reset_n: input, 1 bit, asynchronous active-low reset.
- in_valid: input, NCH bits, per-channel word available.
- in_data: input, NCH*WIDTH bits, flattened; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready: output, NCH bits, per-channel word accepted this cycle.
- force_en: input, 1 bit, manual select mode, which bypasses the arbiter.
- force_sel: input, SW bits, channel index used when force_en=1.
- out_valid: output, 1 bit, the output register holds a word.
- out_data: output, WIDTH bits, the registered word.
- out_chan: output, SW bits, source channel of out_data.
- out_ready: input, 1 bit, the downstream consumer accepts the word.

Function
REQ-007 A transfer on input i SHALL occur in a cycle where in_valid[i]=1 and in_ready[i]=1; an output transfer SHALL occur where out_valid=1 and out_ready=1.
REQ-008 The load condition SHALL be load = (out_valid=0) OR (out_ready=1).
REQ-009 At most one in_ready bit SHALL be 1 per cycle: in_ready[g]=load AND grant_valid, where g is the granted channel.
REQ-010 in_ready SHALL depend combinationally on in_valid, force_en, force_sel and out_ready only; it SHALL never depend on in_data.
REQ-011 On an input transfer from channel g, the next edge SHALL set out_valid=1, out_data=in_data[g] and out_chan=g, giving 1-cycle latency.
REQ-012 If load=1 and no input transfer occurs, the next edge SHALL clear out_valid; out_data and out_chan SHALL hold their last values.
REQ-013 While out_valid=1 and out_ready=0, out_data, out_chan and out_valid SHALL be held stable.
REQ-014 A simultaneous output transfer and input transfer in the same cycle SHALL sustain full throughput of one word per cycle, with no bubble.
REQ-015 When force_en=1, grant SHALL be force_sel if force_sel<NCH and in_valid[force_sel]=1; otherwise no grant, with all in_ready=0.
REQ-016 When force_en=0 and RR_MODE=0, grant SHALL go to the lowest index i with in_valid[i]=1.
REQ-017 When force_en=0 and RR_MODE=1, grant SHALL go to the first channel with in_valid=1, searching from (last_grant+1) mod NCH upward with wrap-around.
REQ-018 last_grant SHALL update to g only on an input transfer, including forced transfers.
REQ-019 A channel deasserting in_valid without a transfer SHALL NOT change last_grant.
REQ-020 When no in_valid bit is set, there SHALL be no grant, and the arbiter state SHALL be held.

Reset
REQ-021 On reset_n=0, asynchronously: out_valid=0, out_data=0, out_chan=0, last_grant=NCH-1, so that channel 0 has first round-robin priority.
REQ-022 While reset_n=0, all in_ready bits SHALL be 0.
REQ-023 Reset asserted mid-stream SHALL discard the held output word with no partial transfer.
REQ-024 The first transfer after reset release SHALL be allowed on the first rising edge with reset_n=1.

Structure
REQ-025 The package stream_mux_pkg SHALL hold the arbitration-mode constants (ARB_FIXED=0, ARB_RR=1) and the index-width function used for SW.
REQ-026 Arbitration SHALL be a separate sub-module rr_arbiter (parameters NCH and RR_MODE; inputs req, last_grant and load; outputs grant and grant_valid).
REQ-027 stream_mux_pkg SHALL be shared with rr_arbiter.
REQ-028 The top level SHALL hold the output register, the last_grant register and the force-select path.

Verification
REQ-029 The bench SHALL cover, with NCH=4, WIDTH=8 and RR_MODE=1:
- Rotation: in_valid=1111 held, out_ready=1 -> out_chan sequence 0,1,2,3,0, one word per cycle, out_data matching each source.
- Backpressure: out_ready=0 for 3 cycles with a word held (out_chan=2, out_data=0xA5) -> outputs stable, in_ready=0000; out_ready=1 -> the next word follows in the next cycle.
- Skip and wrap: last_grant=1, in_valid=1001 -> grant goes to 3, then 0.
- Force: force_en=1, force_sel=2, in_valid=1111 -> only channel 2 is served; force_sel=5 on NCH=4 -> in_ready=0000.
REQ-030 The bench SHALL also cover, with RR_MODE=0: in_valid=0110 held -> every transfer is from channel 1.
REQ-031 The bench SHALL cover reset mid-stream: reset_n low while out_valid=1 -> out_valid=0 and out_data=0 immediately; after release with in_valid=1111 -> the first out_chan is 0.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// -----------------------------------------------------------------------------
// stream_mux_pkg
//   Shared constants and helpers for the round-robin stream multiplexer.
//   - ARB_FIXED / ARB_RR : values accepted by the RR_MODE parameter.
//   - idx_width(n)       : width of a channel index, max(1, clog2(n)).
// -----------------------------------------------------------------------------
package stream_mux_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // A two-channel mux still needs one index bit, so clamp at 1.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : stream_mux_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational channel arbiter.
//   RR_MODE = ARB_RR    : search starts at (last_grant + 1) mod NCH, wrapping.
//   RR_MODE = ARB_FIXED : search starts at channel 0 (lowest index wins).
//
// Ports
//   req         in  [NCH-1:0] per-channel request (in_valid)
//   last_grant  in  [SW-1:0]  channel of the most recent input transfer
//   load        in            output stage can take a word this cycle
//   grant       out [SW-1:0]  selected channel (0 when nothing requested)
//   grant_valid out           a channel was found AND the output can load,
//                             i.e. the grant turns into a transfer
// -----------------------------------------------------------------------------
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int NCH     = 4,
    parameter  int RR_MODE = ARB_RR,
    localparam int SW      = idx_width(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [SW-1:0]  last_grant,
    input  logic           load,
    output logic [SW-1:0]  grant,
    output logic           grant_valid
);

    int   start;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        start = 0;
        if (RR_MODE == ARB_RR) begin
            start = (int'(last_grant) + 1) % NCH;
        end
        // First requester encountered in search order wins; later hits are
        // ignored once found is set.
        for (int k = 0; k < NCH; k++) begin
            if (!found && req[(start + k) % NCH]) begin
                found = 1'b1;
                grant = SW'((start + k) % NCH);
            end
        end
        grant_valid = found & load;
    end

endmodule : rr_arbiter

// File: rtl/stream_mux_rr.sv
// -----------------------------------------------------------------------------
// stream_mux_rr
//   NCH-input, single-output valid/ready stream multiplexer with a one-word
//   registered output stage. Arbitration is round-robin (RR_MODE=1) or fixed
//   priority (RR_MODE=0); force_en bypasses the arbiter and serves force_sel.
//   One word per cycle is sustained when the consumer keeps out_ready high.
//
// Ports
//   clk        in                  rising-edge clock
//   reset_n    in                  asynchronous active-low reset
//   in_valid   in  [NCH-1:0]       per-channel word available
//   in_data    in  [NCH*WIDTH-1:0] channel i at [i*WIDTH +: WIDTH]
//   in_ready   out [NCH-1:0]       one-hot (or zero) accept strobe
//   force_en   in                  manual channel select
//   force_sel  in  [SW-1:0]        channel served while force_en=1
//   out_valid  out                 output register holds a word
//   out_data   out [WIDTH-1:0]     registered word
//   out_chan   out [SW-1:0]        source channel of out_data
//   out_ready  in                  consumer accepts the word
// -----------------------------------------------------------------------------
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int NCH     = 4,
    parameter  int RR_MODE = ARB_RR,
    localparam int SW      = idx_width(NCH)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic [NCH-1:0]       in_ready,
    input  logic                 force_en,
    input  logic [SW-1:0]        force_sel,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SW-1:0]        out_chan,
    input  logic                 out_ready
);

    logic             vld_p1;
    logic [WIDTH-1:0] data_p1;
    logic [SW-1:0]    chan_p1;
    logic [SW-1:0]    last_grant;

    logic             load;
    logic [SW-1:0]    arb_grant;
    logic             arb_valid;
    logic             force_hit;
    logic [SW-1:0]    grant;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;
    logic [NCH-1:0]   rdy_oh;

    // The output register can take a new word when empty or being drained.
    assign load = ~vld_p1 | out_ready;

    rr_arbiter #(
        .NCH     (NCH),
        .RR_MODE (RR_MODE)
    ) u_arb (
        .req         (in_valid),
        .last_grant  (last_grant),
        .load        (load),
        .grant       (arb_grant),
        .grant_valid (arb_valid)
    );

    // Force path: an out-of-range force_sel matches no channel, so nothing
    // is granted. Decoding by comparison avoids indexing past in_valid when
    // NCH is not a power of two.
    always_comb begin
        force_hit = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (force_sel == SW'(i)) begin
                force_hit = in_valid[i];
            end
        end
    end

    always_comb begin
        if (force_en) begin
            grant = force_sel;
            xfer  = force_hit & load;
        end else begin
            grant = arb_grant;
            xfer  = arb_valid;
        end
    end

    // Data select and one-hot ready. Neither depends on in_data for the
    // handshake, only for the word that gets captured.
    always_comb begin
        sel_data = '0;
        rdy_oh   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant == SW'(i)) begin
                sel_data  = in_data[i*WIDTH +: WIDTH];
                rdy_oh[i] = xfer;
            end
        end
    end

    // in_ready is forced low during reset even though load is high then.
    assign in_ready = reset_n ? rdy_oh : '0;

    // ---- stage p1: output register and arbitration history ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1     <= 1'b0;
            data_p1    <= '0;
            chan_p1    <= '0;
            last_grant <= SW'(NCH - 1);
        end else if (load) begin
            vld_p1 <= xfer;
            if (xfer) begin
                data_p1    <= sel_data;
                chan_p1    <= grant;
                last_grant <= grant;
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign out_chan  = chan_p1;

endmodule : stream_mux_rr
